// File: rtl/multiexp_g2_kernel_pkg.sv
// Shared types and constants for the multiexp G2 kernel read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multiexp_g2_kernel_pkg;

    localparam int LEN_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } chk_state_t;

endpackage

// File: rtl/multiexp_g2_kernel_rd_req_fifo.sv
// Generic first-word-fall-through FIFO holding pending burst requests.
// Latency: a push is visible at the head one cycle later; pop is same-cycle.
// Backpressure: full blocks pushes, empty blocks pops; no push-to-pop bypass.
module multiexp_g2_kernel_rd_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multiexp_g2_kernel_rd_beat_checker.sv
// Counts read beats against queued burst lengths, flags last-beat mismatches.
// Latency: request to beat_ready 2 cycles; closing beat to done/err_len 1 cycle.
// Backpressure: req_ready drops when the queue is full; beat_ready only while a burst is active.
module multiexp_g2_kernel_rd_beat_checker
    import multiexp_g2_kernel_pkg::*;
#(
    parameter int C_LEN_WIDTH = LEN_W,
    parameter int C_DEPTH     = 4,
    localparam int OUT_W      = $clog2(C_DEPTH + 1) + 1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [C_LEN_WIDTH-1:0] req_len,
    input  logic                   beat_valid,
    output logic                   beat_ready,
    input  logic                   beat_last,
    output logic                   done,
    output logic                   err_len,
    output logic [OUT_W-1:0]       outstanding,
    output logic                   idle
);

    chk_state_t             state_q;
    chk_state_t             state_d;
    logic [C_LEN_WIDTH-1:0] rem_q;
    logic [C_LEN_WIDTH-1:0] rem_d;
    logic [C_LEN_WIDTH-1:0] head_len;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   rdy_en_q;
    logic                   push;
    logic                   pop;
    logic                   beat_fire;
    logic                   close;
    logic                   err_d;

    // req_ready is held low through reset and for the edge that releases it.
    assign req_ready  = rdy_en_q & ~fifo_full;
    assign push       = req_valid & req_ready;
    assign beat_ready = (state_q == ST_COUNT);
    assign beat_fire  = beat_valid & beat_ready;
    assign idle       = (outstanding == '0);

    multiexp_g2_kernel_rd_req_fifo #(
        .WIDTH (C_LEN_WIDTH),
        .DEPTH (C_DEPTH)
    ) u_req_fifo (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .push     (push),
        .push_dat (req_len),
        .pop      (pop),
        .pop_dat  (head_len),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        close   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    rem_d   = head_len;
                    state_d = ST_COUNT;
                end
            end
            default: begin
                if (beat_fire) begin
                    if ((rem_q == '0) || beat_last) begin
                        close = 1'b1;
                        // Mismatch when last arrives early or is missing on the final beat.
                        err_d = ((rem_q == '0) != beat_last);
                        if (!fifo_empty) begin
                            pop   = 1'b1;
                            rem_d = head_len;
                        end else begin
                            rem_d   = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        rem_d = rem_q - C_LEN_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            done        <= 1'b0;
            err_len     <= 1'b0;
            rdy_en_q    <= 1'b0;
            outstanding <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            done     <= close;
            err_len  <= err_d;
            rdy_en_q <= 1'b1;
            case ({push, close})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
